// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction memory responder with configurable latency and one-entry last-fetch buffer
module imem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_instr,
    output logic        rsp_err,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];

    state_t                  state_q;
    logic [3:0]              cnt_q;
    logic [31:0]             data_q;
    logic                    rsp_valid_q;
    logic                    rsp_err_q;
    logic [31:0]             rsp_instr_q;
    logic                    buf_valid_q, buf_valid_d;
    logic [ADDR_WIDTH-1:0]   buf_tag_q, buf_tag_d;
    logic [31:0]             buf_data_q, buf_data_d;

    logic                    accept;
    logic                    req_err;
    logic                    req_hit;
    logic                    load_ok;
    logic [ADDR_WIDTH-1:0]   req_idx;
    logic [ADDR_WIDTH-1:0]   load_idx;

    assign req_idx   = req_addr[ADDR_WIDTH+1:2];
    assign load_idx  = load_addr[ADDR_WIDTH+1:2];
    assign req_err   = (req_addr[1:0] != 2'b00) || ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);
    assign load_ok   = load_en && ((load_addr >> (ADDR_WIDTH + 2)) == 32'd0);
    assign req_hit   = buf_valid_q && (buf_tag_q == req_idx);
    assign req_ready = (state_q == IDLE);
    assign accept    = req_valid && req_ready;

    assign rsp_valid = rsp_valid_q;
    assign rsp_instr = rsp_instr_q;
    assign rsp_err   = rsp_err_q;

    // Nonblocking write gives read-before-write against a same-edge miss read.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[load_idx] <= load_data;
        end
    end

    // Invalidate is checked against the post-fill tag so it wins over a same-edge fill.
    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        if (accept && !req_err && !req_hit) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = req_idx;
            buf_data_d  = mem[req_idx];
        end
        if (load_ok && (load_idx == buf_tag_d)) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            data_q      <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_instr_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (req_err) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                            rsp_instr_q <= 32'd0;
                        end else if (req_hit) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b0;
                            rsp_instr_q <= buf_data_q;
                        end else begin
                            data_q <= mem[req_idx];
                            cnt_q  <= LAT_M1;
                            if (LAT_M1 == 4'd0) begin
                                state_q     <= RESP;
                                rsp_valid_q <= 1'b1;
                                rsp_err_q   <= 1'b0;
                                rsp_instr_q <= mem[req_idx];
                            end else begin
                                state_q <= BUSY;
                            end
                        end
                    end
                end
                BUSY: begin
                    if (cnt_q <= 4'd1) begin
                        cnt_q       <= 4'd0;
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_instr_q <= data_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state_q     <= IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - directed table-driven bench for imem_responder
module tb_imem_responder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_addr = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_instr;
    logic        rsp_err;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = 32'd0;
    logic [31:0] load_data = 32'd0;

    int n_pass = 0;
    int n_total = 0;

    imem_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_instr(rsp_instr), .rsp_err(rsp_err),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp_instr;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        load_en = 1'b1; load_addr = addr; load_data = data;
        tick();
        load_en = 1'b0;
    endtask

    // Called at the first sample after the acceptance edge; leaves the bench in the RESP cycle.
    task automatic wait_rsp(input string name, input logic [31:0] ei, input logic ee, input int el);
        int n = 1;
        while (!rsp_valid && n < 20) begin
            chk({name, " req_ready busy"}, 32'(req_ready), 32'd0);
            tick();
            n++;
        end
        if (!rsp_valid) begin
            chk({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            chk({name, " latency"}, 32'(n), 32'(el));
            chk({name, " instr"}, rsp_instr, ei);
            chk({name, " err"}, 32'(rsp_err), 32'(ee));
            chk({name, " req_ready resp"}, 32'(req_ready), 32'd0);
        end
    endtask

    task automatic do_fetch(input string name, input logic [31:0] addr, input logic [31:0] ei,
                            input logic ee, input int el);
        chk({name, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_addr = addr; rsp_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        wait_rsp(name, ei, ee, el);
        tick();
        chk({name, " rsp_valid after"}, 32'(rsp_valid), 32'd0);
        chk({name, " req_ready after"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0040, 32'h2008_0005, 32'h0, 1'b0, 0};
        vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 1'b0, 2};
        vecs[2]  = '{1'b0, 32'h0000_0040, 32'h0, 32'h2008_0005, 1'b0, 1};
        vecs[3]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0, 0};
        vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 2};
        vecs[5]  = '{1'b0, 32'h0000_0042, 32'h0, 32'h0, 1'b1, 1};
        vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0, 32'h0, 1'b1, 1};
        vecs[7]  = '{1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0, 1};
        vecs[8]  = '{1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 32'h0, 1'b0, 0};
        vecs[9]  = '{1'b0, 32'h0000_0FFC, 32'h0, 32'hCAFE_F00D, 1'b0, 2};
        vecs[10] = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 32'h0, 1'b0, 0};
        vecs[11] = '{1'b1, 32'h0000_1000, 32'h1234_5678, 32'h0, 1'b0, 0};
        vecs[12] = '{1'b0, 32'h0000_0000, 32'h0, 32'hA5A5_A5A5, 1'b0, 2};
        vecs[13] = '{1'b0, 32'h8000_0040, 32'h0, 32'h0, 1'b1, 1};

        #2;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_instr", rsp_instr, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 14; i++) begin
            if (vecs[i].is_load) do_load(vecs[i].addr, vecs[i].data);
            else do_fetch($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp_instr,
                          vecs[i].exp_err, vecs[i].exp_lat);
        end

        // Backpressure: response held, pending request waits, load during RESP ignored.
        do_load(32'h100, 32'h55AA_55AA);
        do_load(32'h104, 32'h0BAD_F00D);
        req_valid = 1'b1; req_addr = 32'h100; rsp_ready = 1'b0;
        tick();
        req_addr = 32'h104;
        wait_rsp("bp", 32'h55AA_55AA, 1'b0, 2);
        for (int i = 0; i < 5; i++) begin
            if (i == 0) begin
                load_en = 1'b1; load_addr = 32'h100; load_data = 32'h7777_7777;
            end
            tick();
            load_en = 1'b0;
            chk($sformatf("bp hold%0d valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("bp hold%0d instr", i), rsp_instr, 32'h55AA_55AA);
            chk($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp release valid", 32'(rsp_valid), 32'd0);
        chk("bp release req_ready", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        wait_rsp("bp pending", 32'h0BAD_F00D, 1'b0, 2);
        tick();
        do_fetch("bp reload", 32'h100, 32'h7777_7777, 1'b0, 2);

        // Miss accept with same-edge load: old data returned, buffer ends invalid.
        do_load(32'h80, 32'h2222_2222);
        req_valid = 1'b1; req_addr = 32'h80;
        load_en = 1'b1; load_addr = 32'h80; load_data = 32'h1111_1111;
        tick();
        req_valid = 1'b0; load_en = 1'b0;
        wait_rsp("miss+load", 32'h2222_2222, 1'b0, 2);
        tick();
        do_fetch("miss+load next", 32'h80, 32'h1111_1111, 1'b0, 2);

        // Hit accept with same-edge load: old buffered word returned, buffer ends invalid.
        req_valid = 1'b1; req_addr = 32'h80;
        load_en = 1'b1; load_addr = 32'h80; load_data = 32'h3333_3333;
        tick();
        req_valid = 1'b0; load_en = 1'b0;
        wait_rsp("hit+load", 32'h1111_1111, 1'b0, 1);
        tick();
        do_fetch("hit+load next", 32'h80, 32'h3333_3333, 1'b0, 2);
        do_fetch("buffer hit", 32'h80, 32'h3333_3333, 1'b0, 1);

        // Reset during BUSY aborts the miss and clears the buffer.
        req_valid = 1'b1; req_addr = 32'h40;
        tick();
        req_valid = 1'b0;
        chk("pre-reset busy", 32'(req_ready), 32'd0);
        reset = 1'b1;
        #1;
        chk("async reset req_ready", 32'(req_ready), 32'd1);
        chk("async reset rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("reset held rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        tick();
        chk("post reset rsp_valid", 32'(rsp_valid), 32'd0);
        do_fetch("post reset 0x40", 32'h40, 32'hDEAD_BEEF, 1'b0, 2);
        do_fetch("post reset 0x80", 32'h80, 32'h3333_3333, 1'b0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
